// File: rtl/crop_rescale.sv
`timescale 1ns/1ps
// crop_rescale
//   Buffers one IMG_W x IMG_H greyscale image, crops a centred square window whose
//   size is set by the 2-bit scale latched at the first pixel, and nearest-neighbour
//   rescales the window back to IMG_W x IMG_H. Pulses lfsr_step once per image so the
//   upstream augmentation LFSR can advance.
//
//   Optional feature macro: CROP_FLIP_EN
//     defined   -> flip port present, latched with scale; flip=1 mirrors columns.
//     undefined -> no flip port, no mirroring.
//
// Ports
//   clk        clock
//   reset      asynchronous, active-high
//   scale      crop selector (sampled only at the first-pixel handshake)
//   lfsr_step  one-cycle pulse after the final output pixel is accepted
//   in_valid / in_ready / in_data     raster-order input pixel stream
//   out_valid / out_ready / out_data  raster-order output pixel stream
//   out_last   marks the final output pixel of the image
//   flip       horizontal mirror request (CROP_FLIP_EN only)
module crop_rescale #(
    parameter int IMG_W     = 28,
    parameter int IMG_H     = 28,
    parameter int PIX_W     = 8,
    parameter int CROP_STEP = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       scale,
    output logic             lfsr_step,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_data,
    output logic             out_last
`ifdef CROP_FLIP_EN
    ,
    input  logic             flip
`endif
);

    localparam int NPIX  = IMG_W * IMG_H;
    localparam int IW    = $clog2(NPIX);
    localparam int XW    = $clog2(IMG_W);
    localparam int MAXD  = (IMG_W > IMG_H) ? IMG_W : IMG_H;
    localparam int AW    = $clog2(2 * MAXD);

    typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;

    state_t           state;
    logic [PIX_W-1:0] fb [NPIX];

    logic [IW-1:0]    wr_idx;
    logic [AW-1:0]    crop_w_r;
    logic [AW-1:0]    crop_h_r;
    logic [XW-1:0]    off_r;

    // DDA state: output column, source column/accumulator, row accumulator and the
    // raster index of the current source row (sy*IMG_W kept incrementally).
    logic [XW-1:0]    ox;
    logic [XW-1:0]    sx;
    logic [AW-1:0]    ax;
    logic [AW-1:0]    ay;
    logic [IW-1:0]    rbase;
    logic [IW-1:0]    emit_cnt;
    logic             emit_done;

    // Window geometry derived from the live scale input, used only when it is latched.
    logic [AW-1:0]    crop_w_in;
    logic [AW-1:0]    crop_h_in;
    logic [XW-1:0]    off_in;
    logic [IW-1:0]    row0_in;

    logic [AW-1:0]    ax_sum;
    logic [AW-1:0]    ay_sum;
    logic [XW-1:0]    col;
    logic [IW-1:0]    src_idx;

`ifdef CROP_FLIP_EN
    logic             flip_r;
`endif

    always_comb begin
        crop_w_in = AW'(IMG_W - scale * CROP_STEP);
        crop_h_in = AW'(IMG_H - scale * CROP_STEP);
        off_in    = XW'(scale * CROP_STEP / 2);
        row0_in   = IW'(off_in * IMG_W);
    end

    always_comb begin
        ax_sum = ax + crop_w_r;
        ay_sum = ay + crop_h_r;
`ifdef CROP_FLIP_EN
        // off + crop - 1 - (sx - off) collapses to IMG_W-1-sx since 2*off + crop = IMG_W.
        col = flip_r ? (XW'(IMG_W - 1) - sx) : sx;
`else
        col = sx;
`endif
        src_idx = rbase + IW'(col);
    end

    // Frame buffer carries no reset; its contents are only read after a full load.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready)
            fb[wr_idx] <= in_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            lfsr_step <= 1'b0;
            wr_idx    <= '0;
            crop_w_r  <= '0;
            crop_h_r  <= '0;
            off_r     <= '0;
            ox        <= '0;
            sx        <= '0;
            ax        <= '0;
            ay        <= '0;
            rbase     <= '0;
            emit_cnt  <= '0;
            emit_done <= 1'b0;
`ifdef CROP_FLIP_EN
            flip_r    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        crop_w_r  <= crop_w_in;
                        crop_h_r  <= crop_h_in;
                        off_r     <= off_in;
`ifdef CROP_FLIP_EN
                        flip_r    <= flip;
`endif
                        ox        <= '0;
                        sx        <= off_in;
                        ax        <= '0;
                        ay        <= '0;
                        rbase     <= row0_in;
                        emit_cnt  <= '0;
                        emit_done <= 1'b0;
                        wr_idx    <= IW'(1);
                        state     <= LOAD;
                    end
                end

                LOAD: begin
                    if (in_valid && in_ready) begin
                        if (wr_idx == IW'(NPIX - 1)) begin
                            wr_idx   <= '0;
                            in_ready <= 1'b0;
                            state    <= EMIT;
                        end else begin
                            wr_idx <= wr_idx + IW'(1);
                        end
                    end
                end

                EMIT: begin
                    if (!out_valid || out_ready) begin
                        if (!emit_done) begin
                            out_valid <= 1'b1;
                            out_data  <= fb[src_idx];
                            out_last  <= (emit_cnt == IW'(NPIX - 1));
                            if (emit_cnt == IW'(NPIX - 1))
                                emit_done <= 1'b1;
                            emit_cnt <= emit_cnt + IW'(1);
                            if (ox == XW'(IMG_W - 1)) begin
                                ox <= '0;
                                sx <= off_r;
                                ax <= '0;
                                if (ay_sum >= AW'(IMG_H)) begin
                                    ay    <= ay_sum - AW'(IMG_H);
                                    rbase <= rbase + IW'(IMG_W);
                                end else begin
                                    ay <= ay_sum;
                                end
                            end else begin
                                ox <= ox + XW'(1);
                                if (ax_sum >= AW'(IMG_W)) begin
                                    ax <= ax_sum - AW'(IMG_W);
                                    sx <= sx + XW'(1);
                                end else begin
                                    ax <= ax_sum;
                                end
                            end
                        end else begin
                            // Everything issued: a pending valid here is the last
                            // pixel being accepted.
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            if (out_valid) begin
                                lfsr_step <= 1'b1;
                                state     <= DONE;
                            end
                        end
                    end
                end

                DONE: begin
                    lfsr_step <= 1'b0;
                    in_ready  <= 1'b1;
                    emit_done <= 1'b0;
                    emit_cnt  <= '0;
                    state     <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crop_rescale.sv
`timescale 1ns/1ps
// Scoreboard bench for crop_rescale: stimulus pushes expected pixels, a monitor pops
// and compares on every output handshake.
module tb_crop_rescale;

    localparam int W    = 28;
    localparam int H    = 28;
    localparam int CS   = 4;
    localparam int NPIX = W * H;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] scale;
    logic       lfsr_step;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       flip;

    crop_rescale #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .CROP_STEP(CS)) dut (
        .clk       (clk),
        .reset     (reset),
        .scale     (scale),
        .lfsr_step (lfsr_step),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
`ifdef CROP_FLIP_EN
        ,
        .flip      (flip)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } exp_t;

    exp_t exp_q[$];
    int   passed = 0;
    int   total  = 0;
    int   img_cnt = 0;
    int   step_cnt = 0;
    bit   pending_last = 0;
    bit   prev_step = 0;
    bit   prev_stall = 0;
    logic [7:0] prev_d;
    logic       prev_l;
    int   spot_idx[4];
    int   spot_val[4];
    int   spot_n = 0;
    int   steps_exp = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: actual %0d required %0d", name, act, req);
    endtask

    function automatic logic [7:0] exp_pix(input int s, input int f, input int y, input int x);
        int cw, ch, off, sx, sy;
        cw  = W - s * CS;
        ch  = H - s * CS;
        off = s * CS / 2;
        sx  = (f != 0) ? off + cw - 1 - (x * cw) / W : off + (x * cw) / W;
        sy  = off + (y * ch) / H;
        return 8'((sy * W + sx) % 256);
    endfunction

    task automatic send_image(input logic [1:0] s0, input logic [1:0] s1, input int chg_at,
                              input logic f);
        int i;
        int guard;
        exp_t e;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                e.d = exp_pix(int'(s0), int'(f), y, x);
                e.l = (y == H - 1) && (x == W - 1);
                exp_q.push_back(e);
            end
        i = 0;
        guard = 0;
        while (i < NPIX && guard < 4 * NPIX) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = 8'(i % 256);
            scale    = (i >= chg_at) ? s1 : s0;
            flip     = f;
            if (in_ready) i++;
            guard++;
        end
        if (i < NPIX) check("load_timeout", i, NPIX);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_steps(input int target);
        int g;
        g = 0;
        while (step_cnt < target && g < 5000) begin
            @(negedge clk);
            g++;
        end
        check("image_done", step_cnt, target);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 0;
                prev_step  = 0;
            end else begin
                if (prev_step) begin
                    check("step_width", int'(lfsr_step), 0);
                    check("ready_after_step", int'(in_ready), 1);
                end
                prev_step = lfsr_step;
                if (lfsr_step) begin
                    check("step_after_last", int'(pending_last), 1);
                    pending_last = 0;
                    step_cnt++;
                end
                if (prev_stall) begin
                    check("stall_valid", int'(out_valid), 1);
                    check("stall_data", int'(out_data), int'(prev_d));
                    check("stall_last", int'(out_last), int'(prev_l));
                end
                prev_stall = out_valid && !out_ready;
                prev_d = out_data;
                prev_l = out_last;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("pix_data", int'(out_data), int'(e.d));
                        check("pix_last", int'(out_last), int'(e.l));
                    end
                    for (int k = 0; k < spot_n; k++)
                        if (img_cnt == spot_idx[k])
                            check("spot_pixel", int'(out_data), spot_val[k]);
                    img_cnt++;
                    if (out_last) begin
                        check("pix_count", img_cnt, NPIX);
                        img_cnt = 0;
                        pending_last = 1;
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        int s;
        int g;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        scale = 2'd0; flip = 1'b0; in_data = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_lfsr_step", int'(lfsr_step), 0);
        reset = 1'b0;

        // identity at scale 0
        send_image(2'd0, 2'd0, NPIX, 1'b0);
        steps_exp++; wait_steps(steps_exp);

        // scale 3: crop 16, offset 6
        spot_idx = '{0, 1, 2, 783};
        spot_val = '{174, 174, 175, 97};
        spot_n = 4;
        send_image(2'd3, 2'd3, NPIX, 1'b0);
        steps_exp++; wait_steps(steps_exp);
        spot_n = 0;

        // scale change mid-load is ignored; next image latches its own first-pixel scale
        send_image(2'd3, 2'd1, 100, 1'b0);
        steps_exp++; wait_steps(steps_exp);
        send_image(2'd1, 2'd2, 300, 1'b0);
        steps_exp++; wait_steps(steps_exp);

        // back-pressure for 5 cycles mid-emit
        send_image(2'd2, 2'd2, NPIX, 1'b0);
        repeat (100) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
        steps_exp++; wait_steps(steps_exp);

        // reset during emit
        send_image(2'd3, 2'd3, NPIX, 1'b0);
        g = 0;
        while (img_cnt < 50 && g < 3000) begin
            @(negedge clk);
            g++;
        end
        check("emit_started", int'(img_cnt >= 50), 1);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_lfsr_step", int'(lfsr_step), 0);
        exp_q.delete();
        img_cnt = 0;
        pending_last = 0;
        s = step_cnt;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(negedge clk);
        check("no_step_after_reset", step_cnt, s);
        steps_exp = s;
        send_image(2'd1, 2'd1, NPIX, 1'b0);
        steps_exp++; wait_steps(steps_exp);

`ifdef CROP_FLIP_EN
        spot_idx = '{0, 27, 0, 0};
        spot_val = '{189, 174, 189, 189};
        spot_n = 2;
        send_image(2'd3, 2'd3, NPIX, 1'b1);
        steps_exp++; wait_steps(steps_exp);
        spot_n = 0;
`endif

        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
